// File: rtl/mem_bank_pkg.sv
// Shared definitions for the memory bank port: default widths used by both
// initiator and responder, the command encoding, and a counter-width helper.
package mem_bank_pkg;

  localparam int DATA_WIDTH_DEF    = 128;
  localparam int TAG_WIDTH_DEF     = 2;
  localparam int ADDRESS_WIDTH_DEF = 32;
  localparam int BE_WIDTH_DEF      = DATA_WIDTH_DEF / 8;

  // Encoding of the w strobe when ce=1.
  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } cmd_e;

  // Bits needed to hold a count from 0 up to and including max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_bank_rd_pipe.sv
// Fixed-depth read pipeline: carries {valid, tag, word address} of each
// accepted read so the RAM lookup and the response line up with the latency.
// A synchronous reset flushes every stage, so in-flight reads are dropped.
module mem_bank_rd_pipe #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 2,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_valid,
  output logic [TAG_W-1:0]  o_tag,
  output logic [ADDR_W-1:0] o_addr
);

  typedef struct packed {
    logic              vld;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] addr;
  } stage_t;

  stage_t r_stage    [DEPTH];
  stage_t w_stage_in [DEPTH];

  // Stage 0 takes the new command, every later stage takes its predecessor.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign w_stage_in[gi] = '{vld: i_valid, tag: i_tag, addr: i_addr};
      end else begin : g_body
        assign w_stage_in[gi] = r_stage[gi-1];
      end
    end
  endgenerate

  // Shift all stages each clock; reset clears them so no stale valid survives.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        r_stage[i] <= '0;
      end else begin
        r_stage[i] <= w_stage_in[i];
      end
    end
  end

  assign o_valid = r_stage[DEPTH-1].vld;
  assign o_tag   = r_stage[DEPTH-1].tag;
  assign o_addr  = r_stage[DEPTH-1].addr;

endmodule

// File: rtl/mem_bank_resp.sv
// Bank-side responder for one memory bank port. Holds a byte-enabled word
// RAM, returns reads with a fixed latency and echoed tag, and throttles the
// initiator with a registered ready that drops for an outstanding-read limit
// and for a periodic refresh window.
//
// Legal ranges: RD_LATENCY 2..16, MAX_OUT 1..15. REFRESH_PERIOD=0 disables
// refresh. The RAM word for a read is fetched on the edge that raises valid,
// so any write accepted before that edge is reflected in the returned data.
module mem_bank_resp
  import mem_bank_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int TAG_WIDTH      = TAG_WIDTH_DEF,
  parameter int ADDRESS_WIDTH  = ADDRESS_WIDTH_DEF,
  parameter int BE_WIDTH       = BE_WIDTH_DEF,
  parameter int DEPTH_LOG2     = 10,
  parameter int RD_LATENCY     = 4,
  parameter int MAX_OUT        = 8,
  parameter int REFRESH_PERIOD = 1024,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic                     ce,
  input  logic                     w,
  input  logic [ADDRESS_WIDTH-1:0] a,
  input  logic [TAG_WIDTH-1:0]     tag,
  input  logic [DATA_WIDTH-1:0]    d,
  input  logic [BE_WIDTH-1:0]      be,
  output logic                     ready,
  output logic                     valid,
  output logic [DATA_WIDTH-1:0]    q,
  output logic [TAG_WIDTH-1:0]     qtag
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int OUT_W = cnt_width(MAX_OUT);

  // Command decode
  cmd_e                  w_cmd;
  logic                  w_accept;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [DEPTH_LOG2-1:0] w_addr;

  // Flow control
  logic             r_ready;
  logic             w_ready_next;
  logic [OUT_W-1:0] r_outstanding;
  logic [OUT_W-1:0] w_outstanding_next;
  logic             w_refresh_next;

  // Read path
  logic                  w_pipe_valid;
  logic [TAG_WIDTH-1:0]  w_pipe_tag;
  logic [DEPTH_LOG2-1:0] w_pipe_addr;
  logic                  r_valid;
  logic [TAG_WIDTH-1:0]  r_qtag;
  logic [DATA_WIDTH-1:0] r_q;

  logic [DATA_WIDTH-1:0] r_mem [WORDS];

  // A command only lands on an edge where ready was already high; the
  // reset edge never accepts, so nothing is written while resetting.
  assign w_cmd    = cmd_e'(w);
  assign w_accept = ce & r_ready & ~rst;
  assign w_rd_acc = w_accept & (w_cmd == CMD_RD);
  assign w_wr_acc = w_accept & (w_cmd == CMD_WR);
  assign w_addr   = a[DEPTH_LOG2-1:0];

  // Upper address bits alias onto the same words and are deliberately dropped.
  generate
    if (ADDRESS_WIDTH > DEPTH_LOG2) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^a[ADDRESS_WIDTH-1:DEPTH_LOG2];
    end
  endgenerate

  // Free-running refresh counter; the window covers the first REFRESH_CYCLES
  // counts of every period and only gates ready, never the read pipeline.
  generate
    if (REFRESH_PERIOD > 0) begin : g_refresh
      localparam int RC_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
      logic [RC_W-1:0] r_refresh_cnt;
      logic [RC_W-1:0] w_refresh_cnt_next;

      assign w_refresh_cnt_next = (r_refresh_cnt == RC_W'(REFRESH_PERIOD - 1))
                                  ? '0 : r_refresh_cnt + 1'b1;
      assign w_refresh_next     = (32'(w_refresh_cnt_next) < REFRESH_CYCLES);

      // Advance the refresh phase every clock.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_refresh_cnt <= '0;
        end else begin
          r_refresh_cnt <= w_refresh_cnt_next;
        end
      end
    end else begin : g_no_refresh
      assign w_refresh_next = 1'b0;
    end
  endgenerate

  // Outstanding reads: count up on a read accept, down when its valid is
  // presented; both in one cycle leave the count unchanged.
  always_comb begin
    w_outstanding_next = r_outstanding;
    case ({w_rd_acc, r_valid})
      2'b10:   w_outstanding_next = r_outstanding + 1'b1;
      2'b01:   w_outstanding_next = r_outstanding - 1'b1;
      default: w_outstanding_next = r_outstanding;
    endcase
  end

  // ready looks one cycle ahead so that, as a register, it is never high
  // when accepting would push the count past MAX_OUT.
  assign w_ready_next = req & ~w_refresh_next &
                        (w_outstanding_next < OUT_W'(MAX_OUT));

  // Flow-control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready       <= 1'b0;
      r_outstanding <= '0;
    end else begin
      r_ready       <= w_ready_next;
      r_outstanding <= w_outstanding_next;
    end
  end

  // RAM write port with per-byte enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (be[i]) begin
          r_mem[w_addr][8*i +: 8] <= d[8*i +: 8];
        end
      end
    end
  end

  mem_bank_rd_pipe #(
    .DEPTH  (RD_LATENCY),
    .TAG_W  (TAG_WIDTH),
    .ADDR_W (DEPTH_LOG2)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_rd_acc),
    .i_tag   (tag),
    .i_addr  (w_addr),
    .o_valid (w_pipe_valid),
    .o_tag   (w_pipe_tag),
    .o_addr  (w_pipe_addr)
  );

  // Registered RAM read, enabled only for a returning read so q holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (w_pipe_valid) begin
      r_q <= r_mem[w_pipe_addr];
    end
  end

  // Response strobe and tag; the tag holds between returns like q.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_qtag  <= '0;
    end else begin
      r_valid <= w_pipe_valid;
      if (w_pipe_valid) begin
        r_qtag <= w_pipe_tag;
      end
    end
  end

  assign ready = r_ready;
  assign valid = r_valid;
  assign q     = r_q;
  assign qtag  = r_qtag;

endmodule

// File: tb/tb_mem_bank_resp.sv
// Scoreboard bench for mem_bank_resp: the stimulus thread pushes the expected
// return (data, tag, arrival cycle) of each accepted read; a monitor pops and
// compares whenever valid is seen. MAX_OUT is set to 3 so the outstanding
// limit engages while RD_LATENCY=4 returns are still in flight.
module tb_mem_bank_resp;
  import mem_bank_pkg::*;

  localparam int DW   = 128;
  localparam int TW   = 2;
  localparam int AW   = 32;
  localparam int BW   = 16;
  localparam int LAT  = 4;
  localparam int MAXO = 3;
  localparam int RP   = 1024;
  localparam int RCY  = 8;

  localparam logic [DW-1:0] D5   = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam logic [DW-1:0] D3   = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98;
  localparam logic [DW-1:0] D9   = 128'hA5A5_5A5A_0F0F_F0F0_1357_9BDF_2468_ACE0;
  localparam logic [DW-1:0] ONES = {DW{1'b1}};
  localparam logic [DW-1:0] BE_EXP = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          ce  = 1'b0;
  logic          w   = 1'b0;
  logic [AW-1:0] a   = '0;
  logic [TW-1:0] tag = '0;
  logic [DW-1:0] d   = '0;
  logic [BW-1:0] be  = '0;
  logic          ready;
  logic          valid;
  logic [DW-1:0] q;
  logic [TW-1:0] qtag;

  always #5 clk = ~clk;

  mem_bank_resp #(
    .RD_LATENCY (LAT),
    .MAX_OUT    (MAXO)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .ce    (ce),
    .w     (w),
    .a     (a),
    .tag   (tag),
    .d     (d),
    .be    (be),
    .ready (ready),
    .valid (valid),
    .q     (q),
    .qtag  (qtag)
  );

  // Edges since reset released; mirrors the refresh phase independently.
  int c = 0;
  always @(posedge clk) c <= rst ? 0 : c + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every valid must match the oldest expected return.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got qtag=%0d q=%h expected no return", qtag, q);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", q, e.data);
        chk("rd_tag", DW'(qtag), DW'(e.tag));
        chk("rd_latency", DW'(c), DW'(e.cyc));
        $display("RET  tag=%0d q=%h cycle=%0d", qtag, q, c);
      end
    end
  end

  // Drive one command (called at a negedge) and hold it until accepted.
  // Leaves ce high so commands can be chained back to back.
  task automatic issue(input cmd_e cmd, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [BW-1:0] bemask, input logic [TW-1:0] t,
                       input logic [DW-1:0] exp_data, output int acc);
    int waited;
    waited = 0;
    ce = 1'b1; w = cmd; a = addr; d = data; be = bemask; tag = t;
    while (ready !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got ready=%b after %0d cycles expected 1", ready, waited);
      ce = 1'b0;
      acc = -1;
      return;
    end
    @(negedge clk);
    acc = c;
    if (cmd == CMD_RD) exp_q.push_back('{exp_data, t, c + LAT});
    $display("CMD  %s a=%h tag=%0d be=%h accepted cycle=%0d",
             (cmd == CMD_WR) ? "WR" : "RD", addr, t, bemask, c);
  endtask

  task automatic idle();
    ce = 1'b0;
  endtask

  // Wait until the refresh phase is clear of the window for `margin` cycles.
  task automatic wait_clear(input int margin);
    int n;
    n = 0;
    while (((c % RP) < RCY || (c % RP) > RP - margin) && n < 3000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    while ((c % RP) != ph && n < 2100) begin
      @(negedge clk);
      n++;
    end
    chk("phase_reached", DW'(c % RP), DW'(ph));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", DW'(exp_q.size()), DW'(0));
  endtask

  initial begin : stim
    int acc;
    int accs[6];
    int v0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ready", DW'(ready), DW'(0));
    chk("reset_valid", DW'(valid), DW'(0));
    chk("reset_q", q, '0);
    chk("reset_qtag", DW'(qtag), DW'(0));
    rst = 1'b0;

    // req low keeps the bank closed
    repeat (5) @(negedge clk);
    chk("idle_ready", DW'(ready), DW'(0));
    chk("idle_valid", DW'(valid), DW'(0));
    wait_clear(60);
    chk("pre_req_ready", DW'(ready), DW'(0));
    req = 1'b1;
    @(negedge clk);
    chk("req_ready", DW'(ready), DW'(1));

    // Full write then tagged read; byte enables; address alias
    issue(CMD_WR, 32'd5, D5, 16'hFFFF, 2'd0, '0, acc);
    issue(CMD_RD, 32'd5, '0, 16'h0000, 2'd2, D5, acc);
    issue(CMD_WR, 32'd7, ONES, 16'hFFFF, 2'd0, '0, acc);
    issue(CMD_WR, 32'd7, '0, 16'h00FF, 2'd0, '0, acc);
    issue(CMD_RD, 32'd7, '0, 16'h0000, 2'd1, BE_EXP, acc);
    issue(CMD_WR, 32'h0000_0403, D3, 16'hFFFF, 2'd0, '0, acc);
    issue(CMD_RD, 32'd3, '0, 16'h0000, 2'd3, D3, acc);
    issue(CMD_RD, 32'hFFFF_FC05, '0, 16'h0000, 2'd1, D5, acc);
    idle();
    drain();

    // Outputs hold after the last return
    repeat (3) @(negedge clk);
    chk("hold_valid", DW'(valid), DW'(0));
    chk("hold_q", q, D5);
    chk("hold_qtag", DW'(qtag), DW'(1));

    // Outstanding limit with ce held: 3 accepts, pause, resume after returns
    wait_clear(60);
    for (int i = 0; i < 6; i++) begin
      issue(CMD_RD, AW'(3 + 2 * (i % 3)), '0, 16'h0000, TW'(i),
            (i % 3 == 0) ? D3 : (i % 3 == 1) ? D5 : BE_EXP, accs[i]);
    end
    idle();
    chk("lim_acc1", DW'(accs[1] - accs[0]), DW'(1));
    chk("lim_acc2", DW'(accs[2] - accs[0]), DW'(2));
    chk("lim_acc3", DW'(accs[3] - accs[0]), DW'(6));
    chk("lim_acc4", DW'(accs[4] - accs[0]), DW'(7));
    chk("lim_acc5", DW'(accs[5] - accs[0]), DW'(8));
    drain();

    // Refresh window: ready low for 8 cycles, held write accepted right after
    wait_phase(RP - 1);
    chk("pre_refresh_ready", DW'(ready), DW'(1));
    @(negedge clk);
    chk("refresh_ready", DW'(ready), DW'(0));
    issue(CMD_WR, 32'd9, D9, 16'hFFFF, 2'd0, '0, acc);
    chk("refresh_accept_phase", DW'(acc % RP), DW'(RCY + 1));
    issue(CMD_RD, 32'd9, '0, 16'h0000, 2'd3, D9, acc);
    idle();
    drain();

    // Reset with three reads in flight: none may return
    wait_clear(60);
    issue(CMD_RD, 32'd5, '0, 16'h0000, 2'd0, D5, accs[0]);
    issue(CMD_RD, 32'd7, '0, 16'h0000, 2'd1, BE_EXP, accs[1]);
    issue(CMD_RD, 32'd3, '0, 16'h0000, 2'd2, D3, accs[2]);
    idle();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    v0 = n_valid;
    @(negedge clk);
    rst = 1'b0;
    chk("flush_ready", DW'(ready), DW'(0));
    repeat (12) @(negedge clk);
    chk("flush_no_valid", DW'(n_valid - v0), DW'(0));
    issue(CMD_RD, 32'd5, '0, 16'h0000, 2'd2, D5, accs[0]);
    issue(CMD_RD, 32'd7, '0, 16'h0000, 2'd1, BE_EXP, accs[1]);
    issue(CMD_RD, 32'd9, '0, 16'h0000, 2'd3, D9, accs[2]);
    idle();
    chk("post_rst_acc1", DW'(accs[1] - accs[0]), DW'(1));
    chk("post_rst_acc2", DW'(accs[2] - accs[0]), DW'(2));
    drain();

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no completion expected finish within 40000 cycles");
    $fatal(1);
  end

endmodule
